// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the controller state encoding and the default operand width.
package seq_multiplier_pkg;

    localparam int DEFAULT_WORD_LENGTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_step.sv
// Step counter for the multiplier: clears on capture, counts while enabled,
// and flags the final step with a terminal-count output.
module step_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over enable so a new operation always restarts at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with optional two's-complement operands.
// Works on magnitudes, one multiplier bit per cycle, then restores the sign.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic                       ready,
    output logic                       done,
    output logic                       load_en,
    output logic [2*WORD_LENGTH-1:0]   product
);

    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam int PW    = 2 * WORD_LENGTH;

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]          acc_q, acc_d;
    logic                   sign_q, sign_d;
    logic [PW-1:0]          product_q, product_d;

    logic                   cnt_en;
    logic                   cnt_clr;
    logic                   cnt_tc;

    logic [WORD_LENGTH:0]   partial_sum;
    logic [PW-1:0]          acc_step;

    // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
    function automatic logic [WORD_LENGTH-1:0] magnitude(
        input logic [WORD_LENGTH-1:0] value,
        input logic                   negate
    );
        return negate ? (-value) : value;
    endfunction

    step_counter #(
        .WIDTH (CNT_W),
        .LAST  (CNT_W'(WORD_LENGTH - 1))
    ) u_step_counter (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (cnt_en),
        .clr_i (cnt_clr),
        .tc_o  (cnt_tc)
    );

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign partial_sum = {1'b0, acc_q[PW-1:WORD_LENGTH]}
                       + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step    = {partial_sum, acc_q[WORD_LENGTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        product_d = product_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    mcand_d = magnitude(multiplicand,
                                        signed_mode & multiplicand[WORD_LENGTH-1]);
                    acc_d   = {{WORD_LENGTH{1'b0}},
                               magnitude(multiplier,
                                         signed_mode & multiplier[WORD_LENGTH-1])};
                    sign_d  = signed_mode
                            & (multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1]);
                    cnt_clr = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_en = 1'b1;
                acc_d  = acc_step;
                if (cnt_tc) begin
                    product_d = sign_q ? (-acc_step) : acc_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            product_q <= product_d;
        end
    end

    assign load_en = done;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WORD_LENGTH=16.
// Expected products are hand-computed constants.
module tb_seq_multiplier;

    localparam int WL = 16;
    localparam int LATENCY = WL;
    localparam int MAX_WAIT = 40;

    logic            clk;
    logic            reset;
    logic            start;
    logic            signed_mode;
    logic [WL-1:0]   multiplicand;
    logic [WL-1:0]   multiplier;
    logic            ready;
    logic            done;
    logic            load_en;
    logic [2*WL-1:0] product;

    int totalChecks = 0;
    int badChecks   = 0;
    logic [2*WL-1:0] lastExpected = '0;

    seq_multiplier #(.WORD_LENGTH(WL)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .load_en      (load_en),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic applyStimulus(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                 input logic sgn);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sgn;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [WL-1:0] a,
                         input logic [WL-1:0] b, input logic sgn,
                         input logic [2*WL-1:0] expected);
        int waitCycles;
        applyStimulus(a, b, sgn);
        checkOutput({tag, "_readyLow"}, 64'(ready), 64'd0);
        waitCycles = 0;
        while (done !== 1'b1 && waitCycles < MAX_WAIT) begin
            @(negedge clk);
            waitCycles++;
            if (waitCycles == LATENCY / 2)
                checkOutput({tag, "_holdInCalc"}, 64'(product), 64'(lastExpected));
        end
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_latency"}, 64'(waitCycles), 64'(LATENCY));
        checkOutput({tag, "_loadEn"}, 64'(load_en), 64'd1);
        checkOutput({tag, "_product"}, 64'(product), 64'(expected));
        lastExpected = expected;
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_readyBack"}, 64'(ready), 64'd1);
        checkOutput({tag, "_productHeld"}, 64'(product), 64'(expected));
    endtask

    initial begin
        int doneCount;
        reset        = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_loadEn", 64'(load_en), 64'd0);
        checkOutput("rst_product", 64'(product), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        runOp("u3x5",      16'd3,     16'd5,     1'b0, 32'h0000_000F);
        runOp("sNeg7x3",   16'hFFF9,  16'h0003,  1'b1, 32'hFFFF_FFEB);
        runOp("uFFF9x3",   16'hFFF9,  16'h0003,  1'b0, 32'h0002_FFEB);
        runOp("uMax",      16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE_0001);
        runOp("sMinMin",   16'h8000,  16'h8000,  1'b1, 32'h4000_0000);
        runOp("sMinx1",    16'h8000,  16'h0001,  1'b1, 32'hFFFF_8000);
        runOp("uZero",     16'h0000,  16'h1234,  1'b0, 32'h0000_0000);

        // Busy: a second start during CALC must be dropped.
        applyStimulus(16'd2, 16'd2, 1'b0);
        doneCount = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            checkOutput($sformatf("busy_ready_c%0d", cyc), 64'(ready),
                        (cyc <= 17) ? 64'd0 : 64'd1);
            if (done === 1'b1) begin
                doneCount++;
                checkOutput("busy_doneCycle", 64'(cyc), 64'd17);
                checkOutput("busy_product", 64'(product), 64'h4);
            end
            if (cyc == 5) begin
                multiplicand = 16'd9;
                multiplier   = 16'd9;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("busy_doneCount", 64'(doneCount), 64'd1);
        lastExpected = 32'h4;

        // Reset mid-operation: abort, no done, then a clean restart.
        applyStimulus(16'd100, 16'd100, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midRst_product", 64'(product), 64'd0);
        checkOutput("midRst_ready", 64'(ready), 64'd1);
        checkOutput("midRst_done", 64'(done), 64'd0);
        lastExpected = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        doneCount = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        checkOutput("midRst_noDone", 64'(doneCount), 64'd0);
        runOp("restart100", 16'd100, 16'd100, 1'b0, 32'h0000_2710);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
